uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART_TRANSMITTER instance between N_CLIENTS byte-stream requesters. Arbitration is round-robin with packet lock: a grant is held until the client's last beat, or until MAX_BURST beats. The block drives the transmitter's write port and respects its buffer-full backpressure. It also owns the transmitter's baud-rate and full-threshold configuration, and applies new values only while idle.

Parameters:
N_CLIENTS, 4, number of requesters (2..8)
MAX_BURST, 16, maximum beats per grant before forced release (1..255)

Ports:
clock_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
req_i  in  N_CLIENTS  per-client request (level)
data_i  in  8*N_CLIENTS  per-client byte; client k at bits [8k+7:8k]
valid_i  in  N_CLIENTS  per-client byte valid
last_i  in  N_CLIENTS  per-client last byte of packet
ready_o  out  N_CLIENTS  per-client byte accepted this cycle when valid_i&ready_o
grant_o  out  N_CLIENTS  one-hot current grant (all zero when idle)
busy_o  out  1  a grant is active
cfg_baud_i  in  2  requested baudrate select
cfg_tresh_i  in  6  requested buffer-full threshold
tx_data_o  out  8  to transmitter data_i
tx_write_o  out  1  to transmitter data_write_i
tx_full_i  in  1  from transmitter data_buffer_full_o
baudrate_select_o  out  2  to transmitter baudrate_select_i
full_tresh_o  out  6  to transmitter data_buffer_full_tresh_i

Behaviour:
- Reset (async, reset_n_i=0):
  - Outputs: ready_o=0, grant_o=0, busy_o=0, tx_write_o=0, tx_data_o=0, baudrate_select_o=0, full_tresh_o=32.
  - State: state=IDLE, last-grant pointer=N_CLIENTS-1, so client 0 wins first. Beat counter=0.
- FSM states: IDLE, XFER.
- IDLE:
  - baudrate_select_o<=cfg_baud_i and full_tresh_o<=cfg_tresh_i every cycle.
  - If any req_i is set, select the first requester scanning from pointer+1 with wrap-around.
  - Register the one-hot grant, update the pointer to the winner, clear the beat counter and go to XFER. IDLE to XFER is one cycle.
- XFER (grant g):
  - ready_o[g] = ~tx_full_i (combinational). Every other ready_o bit = 0.
  - Beat = valid_i[g] & ready_o[g]. On a beat, the next cycle has tx_write_o=1 and tx_data_o=data_i[g]; otherwise tx_write_o=0. Fixed latency of one cycle.
  - Beat counter increments per beat (8 bits).
  - Release condition: a beat with last_i[g]=1, OR a beat that makes the count equal MAX_BURST, OR req_i[g] deasserted with no beat that cycle.
  - On release: grant_o=0 and return to IDLE. The next arbitration happens in that IDLE cycle, so there is a minimum one-cycle gap between grants.
- Configuration outputs are frozen throughout XFER. cfg changes during XFER take effect in the first IDLE cycle.
- tx_full_i asserted mid-packet: stall (ready_o[g]=0) and keep the grant. No timeout.
- Simultaneous requests: strict rotation. A client that just finished has lowest priority next round.
- A single requester re-requesting is re-granted after the one IDLE cycle.
- valid_i without req_i for an ungranted client is ignored (ready_o=0).
- Because of the one-cycle write latency, the threshold programmed must leave at least 1 free entry. Software constraint: cfg_tresh_i ≤ depth-1.
- Reset mid-packet: grant dropped immediately. The partial packet is the client's responsibility.

Decomposition:
- Shared package uart_pkg: baud select encoding constants (BAUD_SEL_0..3), default threshold constant (32), FSM state typedef for arb_state_t.
- One sub-module: rr_arbiter. Ports: req, pointer, one-hot grant. Purely combinational rotate-priority-select, parameterised by N_CLIENTS; pointer register kept in parent.

Test Plan:
1. Reset, then req_i=0001 with a 3-byte packet 0x11,0x22,0x33 (last on 0x33) -> grant_o=0001 one cycle after req; tx_write_o pulses 3 times with data 11,22,33, each one cycle after its beat; then grant_o=0 and busy_o=0.
2. req_i=1111, every client sending 2-byte packets -> grant order 0,1,2,3,0; exactly one IDLE cycle between grants; no interleaved bytes.
3. Client 2 sends 20 bytes with no last, MAX_BURST=16 -> release after 16th beat; if others request, they are served; client 2 resumes its remaining 4 bytes in its next grant.
4. tx_full_i=1 for 5 cycles mid-packet -> ready_o[g]=0 and tx_write_o=0 for those cycles; grant held; transfer resumes with no byte lost or duplicated.
5. cfg_baud_i changed 0→2 and cfg_tresh_i 32→20 during XFER -> outputs unchanged until first IDLE cycle, then 2/20.
6. Assert reset_n_i=0 mid-packet, async w.r.t. clock -> all outputs at reset values immediately; after release, client 0 gets first grant.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: baud select codes,
// the transmitter's default buffer-full threshold and the arbiter FSM states.
package uart_pkg;

  localparam logic [1:0] BAUD_SEL_0 = 2'd0;
  localparam logic [1:0] BAUD_SEL_1 = 2'd1;
  localparam logic [1:0] BAUD_SEL_2 = 2'd2;
  localparam logic [1:0] BAUD_SEL_3 = 2'd3;

  localparam logic [5:0] DEFAULT_TRESH = 6'd32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority select: the first requester after the
// pointer (wrapping around) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_CLIENTS = 4,
  localparam int PW = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [PW-1:0]        pointer,
  output logic [N_CLIENTS-1:0] grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = PW'((int'(pointer) + i) % N_CLIENTS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter write port between
// several byte-stream clients; also owns the transmitter's baud/threshold setup.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic [N_CLIENTS-1:0]     req_i,
  input  logic [8*N_CLIENTS-1:0]   data_i,
  input  logic [N_CLIENTS-1:0]     valid_i,
  input  logic [N_CLIENTS-1:0]     last_i,
  output logic [N_CLIENTS-1:0]     ready_o,
  output logic [N_CLIENTS-1:0]     grant_o,
  output logic                     busy_o,
  input  logic [1:0]               cfg_baud_i,
  input  logic [5:0]               cfg_tresh_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_write_o,
  input  logic                     tx_full_i,
  output logic [1:0]               baudrate_select_o,
  output logic [5:0]               full_tresh_o
);

  localparam int PW = $clog2(N_CLIENTS);

  arb_state_t           state;
  logic [N_CLIENTS-1:0] grant_q;
  logic [N_CLIENTS-1:0] arb_grant;
  logic [PW-1:0]        pointer;
  logic [PW-1:0]        arb_idx;
  logic [7:0]           beat_cnt;
  logic [7:0]           beat_cnt_next;
  logic                 beat;
  logic                 release_grant;

  rr_arbiter #(
    .N_CLIENTS (N_CLIENTS)
  ) u_rr (
    .req     (req_i),
    .pointer (pointer),
    .grant   (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (arb_grant[k]) arb_idx = PW'(k);
    end
  end

  // The pointer always holds the current grantee while in XFER.
  assign ready_o       = (state == XFER) ? (grant_q & {N_CLIENTS{~tx_full_i}}) : '0;
  assign beat          = |(valid_i & ready_o);
  assign beat_cnt_next = beat_cnt + 8'd1;
  assign release_grant = beat ? (last_i[pointer] || (beat_cnt_next == 8'(MAX_BURST)))
                              : !req_i[pointer];
  assign grant_o       = grant_q;
  assign busy_o        = (state == XFER);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state             <= IDLE;
      grant_q           <= '0;
      pointer           <= PW'(N_CLIENTS - 1);
      beat_cnt          <= '0;
      tx_write_o        <= 1'b0;
      tx_data_o         <= '0;
      baudrate_select_o <= BAUD_SEL_0;
      full_tresh_o      <= DEFAULT_TRESH;
    end else begin
      tx_write_o <= beat;
      if (beat) tx_data_o <= data_i[{pointer, 3'b000} +: 8];
      case (state)
        IDLE: begin
          baudrate_select_o <= cfg_baud_i;
          full_tresh_o      <= cfg_tresh_i;
          if (|req_i) begin
            grant_q  <= arb_grant;
            pointer  <= arb_idx;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) beat_cnt <= beat_cnt_next;
          if (release_grant) begin
            grant_q <= '0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: client queues drive the request ports,
// a scoreboard of expected bytes and grants is checked as the DUT produces them.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 16;

  logic             clock_i   = 1'b0;
  logic             reset_n_i = 1'b1;
  logic [N-1:0]     req_i;
  logic [8*N-1:0]   data_i;
  logic [N-1:0]     valid_i;
  logic [N-1:0]     last_i;
  logic [N-1:0]     ready_o;
  logic [N-1:0]     grant_o;
  logic             busy_o;
  logic [1:0]       cfg_baud_i;
  logic [5:0]       cfg_tresh_i;
  logic [7:0]       tx_data_o;
  logic             tx_write_o;
  logic             tx_full_i;
  logic [1:0]       baudrate_select_o;
  logic [5:0]       full_tresh_o;

  uart_tx_arbiter #(
    .N_CLIENTS (N),
    .MAX_BURST (MAXB)
  ) dut (
    .clock_i           (clock_i),
    .reset_n_i         (reset_n_i),
    .req_i             (req_i),
    .data_i            (data_i),
    .valid_i           (valid_i),
    .last_i            (last_i),
    .ready_o           (ready_o),
    .grant_o           (grant_o),
    .busy_o            (busy_o),
    .cfg_baud_i        (cfg_baud_i),
    .cfg_tresh_i       (cfg_tresh_i),
    .tx_data_o         (tx_data_o),
    .tx_write_o        (tx_write_o),
    .tx_full_i         (tx_full_i),
    .baudrate_select_o (baudrate_select_o),
    .full_tresh_o      (full_tresh_o)
  );

  always #5 clock_i = ~clock_i;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          w0;
  logic [7:0]  cq [N][$];
  logic        cl [N][$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_grant_q [$];
  logic [N-1:0] hs = '0;
  logic [N-1:0] prev_grant = '0;
  logic        full_set;
  logic [1:0]  baud_set;
  logic [5:0]  tresh_set;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    cq[k].push_back(b);
    cl[k].push_back(l);
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0);
    for (int k = 0; k < N; k++) if (cq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  // One clock: retire handshakes, drive inputs after the edge, monitor at the falling edge.
  task automatic tick();
    logic [7:0]  tmp_b;
    logic        tmp_l;
    logic [31:0] exp_b;
    logic [31:0] eg;
    @(posedge clock_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && cq[k].size() != 0) begin
        tmp_b = cq[k].pop_front();
        tmp_l = cl[k].pop_front();
      end
    end
    tx_full_i   = full_set;
    cfg_baud_i  = baud_set;
    cfg_tresh_i = tresh_set;
    for (int k = 0; k < N; k++) begin
      req_i[k]           = (cq[k].size() != 0);
      valid_i[k]         = (cq[k].size() != 0);
      data_i[8*k +: 8]   = (cq[k].size() != 0) ? cq[k][0] : 8'h00;
      last_i[k]          = (cl[k].size() != 0) ? cl[k][0] : 1'b0;
    end
    @(negedge clock_i);
    check("write_latency", 32'(tx_write_o), 32'(|hs));
    if (tx_write_o === 1'b1) begin
      wr_count++;
      if (exp_q.size() != 0) exp_b = exp_q.pop_front();
      else exp_b = 32'h1FF;
      check("write_data", 32'(tx_data_o), exp_b);
    end
    if (grant_o !== prev_grant) begin
      if (grant_o !== '0) begin
        check("grant_gap", 32'(prev_grant), 32'h0);
        if (exp_grant_q.size() != 0) eg = exp_grant_q.pop_front();
        else eg = 32'hDEAD;
        check("grant_order", 32'(grant_o), eg);
      end
      prev_grant = grant_o;
    end
    check("ready_mask", 32'(ready_o & ~grant_o), 32'h0);
    check("busy_vs_grant", 32'(busy_o), 32'(|grant_o));
    hs = valid_i & ready_o;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_write", 32'(tx_write_o), 32'h0);
    check("rst_data", 32'(tx_data_o), 32'h0);
    check("rst_baud", 32'(baudrate_select_o), 32'h0);
    check("rst_tresh", 32'(full_tresh_o), 32'd32);
    for (int k = 0; k < N; k++) begin
      cq[k].delete();
      cl[k].delete();
    end
    exp_q.delete();
    exp_grant_q.delete();
    hs         = '0;
    prev_grant = '0;
    req_i      = '0;
    valid_i    = '0;
    last_i     = '0;
    #2;
    reset_n_i = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy_o === 1'b1 || pending()) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_in_budget"}, 32'(n < budget), 32'h1);
    check({tag, "_grants_used"}, 32'(exp_grant_q.size()), 32'h0);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_in_budget"}, 32'(n < budget), 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    full_set = 1'b0; baud_set = 2'd0; tresh_set = 6'd32;
    tx_full_i = 1'b0; cfg_baud_i = 2'd0; cfg_tresh_i = 6'd32;
    req_i = '0; valid_i = '0; last_i = '0; data_i = '0;
    #1;
    do_reset();

    $display("[TB] single 3-byte packet from client 0");
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    exp_grant_q.push_back(32'h1);
    w0 = wr_count;
    tick();
    check("t1_no_grant_yet", 32'(grant_o), 32'h0);
    tick();
    check("t1_grant", 32'(grant_o), 32'h1);
    check("t1_busy", 32'(busy_o), 32'h1);
    drain("t1", 50);
    check("t1_writes", 32'(wr_count - w0), 32'd3);
    check("t1_grant_off", 32'(grant_o), 32'h0);
    check("t1_busy_off", 32'(busy_o), 32'h0);

    $display("[TB] four clients, 2-byte packets, rotation");
    do_reset();
    for (int k = 0; k < N; k++) begin
      push_byte(k, 8'(16*k), 1'b0);
      push_byte(k, 8'(16*k + 1), 1'b1);
    end
    push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h03, 1'b1);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(32'(16*k));
      exp_q.push_back(32'(16*k + 1));
      exp_grant_q.push_back(32'(1 << k));
    end
    exp_q.push_back(32'h02); exp_q.push_back(32'h03);
    exp_grant_q.push_back(32'h1);
    w0 = wr_count;
    drain("t2", 200);
    check("t2_writes", 32'(wr_count - w0), 32'd10);

    $display("[TB] client 2 long stream vs burst limit");
    for (int j = 0; j < 20; j++) push_byte(2, 8'(8'h40 + j), (j == 19));
    push_byte(3, 8'hC0, 1'b0); push_byte(3, 8'hC1, 1'b1);
    for (int j = 0; j < MAXB; j++) exp_q.push_back(32'(8'h40 + j));
    exp_q.push_back(32'hC0); exp_q.push_back(32'hC1);
    for (int j = MAXB; j < 20; j++) exp_q.push_back(32'(8'h40 + j));
    exp_grant_q.push_back(32'h4); exp_grant_q.push_back(32'h8); exp_grant_q.push_back(32'h4);
    w0 = wr_count;
    drain("t3", 300);
    check("t3_writes", 32'(wr_count - w0), 32'd22);

    $display("[TB] transmitter full stall mid-packet");
    for (int j = 0; j < 6; j++) begin
      push_byte(1, 8'(8'hA0 + j), (j == 5));
      exp_q.push_back(32'(8'hA0 + j));
    end
    exp_grant_q.push_back(32'h2);
    w0 = wr_count;
    wait_writes("t4_first", w0 + 2, 50);
    full_set = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_ready", 32'(ready_o), 32'h0);
      check("t4_stall_grant", 32'(grant_o), 32'h2);
      if (i > 0) check("t4_stall_write", 32'(tx_write_o), 32'h0);
    end
    full_set = 1'b0;
    drain("t4", 100);
    check("t4_writes", 32'(wr_count - w0), 32'd6);

    $display("[TB] configuration change during transfer");
    for (int j = 0; j < 4; j++) begin
      push_byte(3, 8'(8'hB0 + j), (j == 3));
      exp_q.push_back(32'(8'hB0 + j));
    end
    exp_grant_q.push_back(32'h8);
    tick();
    tick();
    check("t5_grant", 32'(grant_o), 32'h8);
    baud_set  = 2'd2;
    tresh_set = 6'd20;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_o !== 1'b1) break;
      check("t5_baud_frozen", 32'(baudrate_select_o), 32'h0);
      check("t5_tresh_frozen", 32'(full_tresh_o), 32'd32);
    end
    check("t5_released", 32'(busy_o), 32'h0);
    tick();
    check("t5_baud_new", 32'(baudrate_select_o), 32'h2);
    check("t5_tresh_new", 32'(full_tresh_o), 32'd20);
    drain("t5", 20);

    $display("[TB] asynchronous reset mid-packet");
    for (int j = 0; j < 6; j++) begin
      push_byte(2, 8'(8'h60 + j), (j == 5));
      exp_q.push_back(32'(8'h60 + j));
    end
    exp_grant_q.push_back(32'h4);
    w0 = wr_count;
    wait_writes("t6_partial", w0 + 2, 50);
    check("t6_busy_before", 32'(busy_o), 32'h1);
    do_reset();
    push_byte(3, 8'h78, 1'b0); push_byte(3, 8'h79, 1'b1);
    push_byte(0, 8'h70, 1'b0); push_byte(0, 8'h71, 1'b1);
    exp_q.push_back(32'h70); exp_q.push_back(32'h71);
    exp_q.push_back(32'h78); exp_q.push_back(32'h79);
    exp_grant_q.push_back(32'h1); exp_grant_q.push_back(32'h8);
    w0 = wr_count;
    drain("t6", 100);
    check("t6_writes", 32'(wr_count - w0), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
